// File: rtl/bht_predictor_table_pkg.sv
// Shared constants and sizing helpers for the branch history table.
package bht_pkg;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic int ctr_max(input int ctr_w);
      return (1 << ctr_w) - 1;
   endfunction

   function automatic int depth_of(input int idx_w);
      return 1 << idx_w;
   endfunction

endpackage

// File: rtl/bht_predictor_table_ctr_next.sv
// Saturating up/down step for one prediction counter.
module bht_ctr_next
   import bht_pkg::*;
#(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             taken_i,
   output logic [CTR_W-1:0] ctr_o
);

   localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != MAX) ctr_o = ctr_i + 1'b1;
      end else if (ctr_i != '0) begin
         ctr_o = ctr_i - 1'b1;
      end
   end

endmodule

// File: rtl/bht_predictor_table.sv
// Branch history table: saturating counters, optional gshare indexing,
// registered 1-cycle prediction and a sequenced init/clear sweep.
module bht_predictor_table
   import bht_pkg::*;
#(
   parameter int IDX_W    = 8,
   parameter int CTR_W    = 2,
   parameter int HIST_W   = 8,
   parameter int CTR_INIT = 2**(CTR_W-1)-1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear_i,
   output logic                                ready_o,
   input  logic                                pred_req_i,
   input  logic [IDX_W-1:0]                    pred_addr_i,
   output logic                                pred_valid_o,
   output logic                                pred_taken_o,
   output logic [CTR_W-1:0]                    pred_ctr_o,
   output logic [IDX_W-1:0]                    pred_idx_o,
   input  logic                                upd_valid_i,
   input  logic [IDX_W-1:0]                    upd_idx_i,
   input  logic                                upd_taken_i,
   output logic [(HIST_W > 0 ? HIST_W : 1)-1:0] ghr_o
);

   localparam int DEPTH = depth_of(IDX_W);
   localparam int GW    = (HIST_W > 0) ? HIST_W : 1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic [GW-1:0]    ghr_q, ghr_d, ghr_shift;
   logic [CTR_W-1:0] mem_q [DEPTH];

   logic             run, upd_fire, pred_fire;
   logic [IDX_W-1:0] idx;
   logic [CTR_W-1:0] upd_nxt, rd_ctr;

   logic             pred_valid_q;
   logic [IDX_W-1:0] pred_idx_q;
   logic [CTR_W-1:0] pred_ctr_q;

   assign run       = (state_q == ST_RUN);
   assign upd_fire  = run && upd_valid_i && !clear_i;
   assign pred_fire = run && pred_req_i;

   if (HIST_W > 1) begin : g_gshare
      assign idx       = pred_addr_i ^ IDX_W'(ghr_q);
      assign ghr_shift = {ghr_q[GW-2:0], upd_taken_i};
   end else if (HIST_W == 1) begin : g_gshare1
      assign idx       = pred_addr_i ^ IDX_W'(ghr_q);
      assign ghr_shift = upd_taken_i;
   end else begin : g_bimodal
      assign idx       = pred_addr_i;
      assign ghr_shift = '0;
   end

   bht_ctr_next #(.CTR_W(CTR_W)) u_ctr_next (
      .ctr_i   (mem_q[upd_idx_i]),
      .taken_i (upd_taken_i),
      .ctr_o   (upd_nxt)
   );

   // Write-first bypass: a same-cycle update to the read entry is visible.
   assign rd_ctr = (upd_fire && (upd_idx_i == idx)) ? upd_nxt : mem_q[idx];

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      ghr_d   = ghr_q;
      if (clear_i) begin
         state_d = ST_INIT;
         sweep_d = '0;
         ghr_d   = '0;
      end else if (!run) begin
         sweep_d = sweep_q + 1'b1;
         if (&sweep_q) state_d = ST_RUN;
      end else if (upd_fire) begin
         ghr_d = ghr_shift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         sweep_q      <= '0;
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_idx_q   <= '0;
         pred_ctr_q   <= '0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_fire;
         if (pred_fire) begin
            pred_idx_q <= idx;
            pred_ctr_q <= rd_ctr;
         end
      end
   end

   // Counter array carries no reset; the sweep is what initialises it.
   always_ff @(posedge clk) begin
      if (!run)          mem_q[sweep_q]   <= CTR_W'(CTR_INIT);
      else if (upd_fire) mem_q[upd_idx_i] <= upd_nxt;
   end

   assign ready_o      = run;
   assign pred_valid_o = pred_valid_q;
   assign pred_idx_o   = pred_idx_q;
   assign pred_ctr_o   = pred_ctr_q;
   assign pred_taken_o = pred_ctr_q[CTR_W-1];
   assign ghr_o        = ghr_q;

endmodule

// File: tb/tb_bht_predictor_table.sv
// Bench: a gshare (HIST_W=8) and a bimodal (HIST_W=0) table driven in lockstep
// and checked against an array-based reference model.
module tb_bht_predictor_table;

   logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
   logic       pred_req = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
   logic [7:0] pred_addr = '0, upd_idx = '0;

   logic [1:0]       ready_w, pvld_w, ptkn_w;
   logic [1:0][1:0]  pctr_w;
   logic [1:0][7:0]  pidx_w;
   logic [7:0]       ghr_a;
   logic [0:0]       ghr_b;

   int  tab [2][256];
   int  m_ghr [2], m_sweep [2], m_ctr [2], m_idx [2];
   bit  m_run [2], m_vld [2];
   int  n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   bht_predictor_table #(.IDX_W(8), .CTR_W(2), .HIST_W(8)) u_gs (
      .clk(clk), .rst_n(rst_n), .clear_i(clear), .ready_o(ready_w[0]),
      .pred_req_i(pred_req), .pred_addr_i(pred_addr), .pred_valid_o(pvld_w[0]),
      .pred_taken_o(ptkn_w[0]), .pred_ctr_o(pctr_w[0]), .pred_idx_o(pidx_w[0]),
      .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
      .ghr_o(ghr_a)
   );

   bht_predictor_table #(.IDX_W(8), .CTR_W(2), .HIST_W(0)) u_bm (
      .clk(clk), .rst_n(rst_n), .clear_i(clear), .ready_o(ready_w[1]),
      .pred_req_i(pred_req), .pred_addr_i(pred_addr), .pred_valid_o(pvld_w[1]),
      .pred_taken_o(ptkn_w[1]), .pred_ctr_o(pctr_w[1]), .pred_idx_o(pidx_w[1]),
      .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
      .ghr_o(ghr_b)
   );

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_run[d] = 0; m_sweep[d] = 0; m_ghr[d] = 0;
         m_vld[d] = 0; m_ctr[d] = 0; m_idx[d] = 0;
      end
   endtask

   // One clock of the reference: d=0 is gshare, d=1 bimodal.
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         int idx;
         int t;
         if (!m_run[d]) begin
            tab[d][m_sweep[d]] = 1;
            m_vld[d] = 0;
            if (clear) m_sweep[d] = 0;
            else begin
               m_sweep[d]++;
               if (m_sweep[d] == 256) begin m_run[d] = 1; m_sweep[d] = 0; end
            end
         end else begin
            idx = (d == 0) ? (int'(pred_addr) ^ m_ghr[d]) : int'(pred_addr);
            if (upd_valid && !clear) begin
               t = tab[d][upd_idx];
               tab[d][upd_idx] = upd_taken ? ((t >= 3) ? 3 : t + 1) : ((t <= 0) ? 0 : t - 1);
               if (d == 0) m_ghr[d] = ((m_ghr[d] << 1) | int'(upd_taken)) & 255;
            end
            m_vld[d] = pred_req;
            if (pred_req) begin m_idx[d] = idx; m_ctr[d] = tab[d][idx]; end
            if (clear) begin m_run[d] = 0; m_sweep[d] = 0; m_ghr[d] = 0; end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (ready_w !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", ready_w); end
      n_cmp++; if (pvld_w !== 2'b00) begin n_bad++; $display("FAIL reset_pvalid: got %b want 00", pvld_w); end
      n_cmp++; if (pctr_w !== '0 || ptkn_w !== 2'b00) begin n_bad++; $display("FAIL reset_ctr: got %h/%b want 0", pctr_w, ptkn_w); end
      n_cmp++; if (pidx_w !== '0) begin n_bad++; $display("FAIL reset_idx: got %h want 0", pidx_w); end
      n_cmp++; if (ghr_a !== 8'h00 || ghr_b !== 1'b0) begin n_bad++; $display("FAIL reset_ghr: got %h/%b want 0", ghr_a, ghr_b); end
      rst_n = 1'b1;
      n = 0;
      while (ready_w !== 2'b11 && n < 400) begin cycle(); n++; end
      n_cmp++; if (n != 256) begin n_bad++; $display("FAIL init_sweep_len: got %0d cycles want 256", n); end
      pred_req = 1'b1; pred_addr = 8'h00;
      cycle();
      pred_req = 1'b0;
      n_cmp++; if (pvld_w !== 2'b11) begin n_bad++; $display("FAIL first_pred_valid: got %b want 11", pvld_w); end
      n_cmp++; if (pctr_w[0] !== 2'd1 || pctr_w[1] !== 2'd1 || ptkn_w !== 2'b00) begin
         n_bad++; $display("FAIL first_pred_ctr: got %0d,%0d tk %b want 1,1 tk 00", pctr_w[0], pctr_w[1], ptkn_w); end
      n_cmp++; if (pidx_w !== '0) begin n_bad++; $display("FAIL first_pred_idx: got %h want 0", pidx_w); end
   endtask

   task automatic test_collision();
      pred_req = 1'b1; pred_addr = 8'h20;
      upd_valid = 1'b1; upd_idx = 8'h20; upd_taken = 1'b1;
      cycle();
      pred_req = 1'b0; upd_valid = 1'b0;
      n_cmp++; if (pctr_w[0] !== 2'd2 || pctr_w[1] !== 2'd2) begin
         n_bad++; $display("FAIL collision_ctr: got %0d,%0d want 2,2", pctr_w[0], pctr_w[1]); end
      n_cmp++; if (ptkn_w !== 2'b11) begin n_bad++; $display("FAIL collision_taken: got %b want 11", ptkn_w); end
      n_cmp++; if (pidx_w[0] !== 8'h20 || pidx_w[1] !== 8'h20) begin n_bad++; $display("FAIL collision_idx: got %h want 2020", pidx_w); end
      n_cmp++; if (ghr_a !== 8'h01) begin n_bad++; $display("FAIL collision_ghr: got %h want 01", ghr_a); end
   endtask

   task automatic test_clear();
      int n;
      clear = 1'b1; upd_valid = 1'b1; upd_idx = 8'h30; upd_taken = 1'b1;
      cycle();
      clear = 1'b0; upd_valid = 1'b0;
      n_cmp++; if (ready_w !== 2'b00) begin n_bad++; $display("FAIL clear_ready: got %b want 00", ready_w); end
      n_cmp++; if (ghr_a !== 8'h00) begin n_bad++; $display("FAIL clear_ghr: got %h want 00", ghr_a); end
      n = 0;
      while (ready_w !== 2'b11 && n < 400) begin cycle(); n++; end
      n_cmp++; if (n != 256) begin n_bad++; $display("FAIL clear_sweep_len: got %0d cycles want 256", n); end
      for (int i = 0; i < 6; i++) begin
         pred_req = 1'b1;
         pred_addr = (i == 0) ? 8'h20 : (i == 1) ? 8'h30 : 8'($urandom_range(0, 255));
         cycle();
         n_cmp++; if (pctr_w[0] !== 2'd1 || pctr_w[1] !== 2'd1) begin
            n_bad++; $display("FAIL clear_probe: addr %h got %0d,%0d want 1,1", pred_addr, pctr_w[0], pctr_w[1]); end
      end
      pred_req = 1'b0;
      cycle();
   endtask

   task automatic test_gshare();
      upd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         upd_idx = 8'(8'h40 + i); upd_taken = (i < 2);
         cycle();
      end
      upd_valid = 1'b0;
      n_cmp++; if (ghr_a !== 8'h06 || ghr_b !== 1'b0) begin n_bad++; $display("FAIL gshare_ghr: got %h/%b want 06/0", ghr_a, ghr_b); end
      n_cmp++; if (pvld_w !== 2'b00) begin n_bad++; $display("FAIL gshare_pre_valid: got %b want 00", pvld_w); end
      pred_req = 1'b1; pred_addr = 8'h10;
      cycle();
      pred_req = 1'b0;
      n_cmp++; if (pvld_w !== 2'b11) begin n_bad++; $display("FAIL gshare_valid: got %b want 11", pvld_w); end
      n_cmp++; if (pidx_w[0] !== 8'h16 || pidx_w[1] !== 8'h10) begin
         n_bad++; $display("FAIL gshare_idx: got %h,%h want 16,10", pidx_w[0], pidx_w[1]); end
      cycle();
      n_cmp++; if (pvld_w !== 2'b00) begin n_bad++; $display("FAIL gshare_pulse: got %b want 00", pvld_w); end
      n_cmp++; if (pidx_w[0] !== 8'h16) begin n_bad++; $display("FAIL gshare_hold: got %h want 16", pidx_w[0]); end
   endtask

   task automatic test_bimodal();
      upd_valid = 1'b1; upd_idx = 8'h05; upd_taken = 1'b1;
      repeat (3) cycle();
      upd_valid = 1'b0;
      pred_req = 1'b1; pred_addr = 8'h05;
      cycle();
      pred_req = 1'b0;
      n_cmp++; if (pctr_w[1] !== 2'd3 || ptkn_w[1] !== 1'b1) begin
         n_bad++; $display("FAIL bimodal_sat_hi: got %0d tk %b want 3 tk 1", pctr_w[1], ptkn_w[1]); end
      n_cmp++; if (pctr_w[0] !== 2'(m_ctr[0])) begin n_bad++; $display("FAIL bimodal_gs_ctr: got %0d want %0d", pctr_w[0], m_ctr[0]); end
      upd_valid = 1'b1; upd_taken = 1'b0;
      repeat (4) cycle();
      upd_valid = 1'b0;
      pred_req = 1'b1;
      cycle();
      pred_req = 1'b0;
      n_cmp++; if (pctr_w[1] !== 2'd0 || ptkn_w[1] !== 1'b0) begin
         n_bad++; $display("FAIL bimodal_sat_lo: got %0d tk %b want 0 tk 0", pctr_w[1], ptkn_w[1]); end
   endtask

   task automatic test_midsweep_reset();
      int n;
      int bad_v;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ready_w !== 2'b00 || ghr_a !== 8'h00) begin n_bad++; $display("FAIL async_reset: ready %b ghr %h want 00/00", ready_w, ghr_a); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) cycle();
      n_cmp++; if (ready_w !== 2'b00) begin n_bad++; $display("FAIL midsweep_ready: got %b want 00", ready_w); end
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      n = 0; bad_v = 0;
      while (ready_w !== 2'b11 && n < 400) begin
         pred_req = 1'($urandom_range(0, 1)); pred_addr = 8'($urandom_range(0, 255));
         upd_valid = 1'($urandom_range(0, 1)); upd_idx = 8'($urandom_range(0, 255));
         upd_taken = 1'($urandom_range(0, 1));
         cycle(); n++;
         if (pvld_w !== 2'b00) bad_v++;
      end
      pred_req = 1'b0; upd_valid = 1'b0;
      n_cmp++; if (bad_v != 0) begin n_bad++; $display("FAIL init_ignores_req: %0d cycles with pred_valid, want 0", bad_v); end
      n_cmp++; if (n != 256) begin n_bad++; $display("FAIL midsweep_restart: got %0d cycles want 256", n); end
      n_cmp++; if (ghr_a !== 8'h00) begin n_bad++; $display("FAIL init_ghr: got %h want 00", ghr_a); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 900; c++) begin
         pred_req  = 1'($urandom_range(0, 1));
         pred_addr = 8'($urandom_range(0, 15));
         upd_valid = 1'($urandom_range(0, 1));
         upd_idx   = ($urandom_range(0, 2) == 0) ? 8'(int'(pred_addr) ^ m_ghr[0]) : 8'($urandom_range(0, 15));
         upd_taken = 1'($urandom_range(0, 1));
         clear     = ($urandom_range(0, 349) == 0);
         cycle();
         for (int d = 0; d < 2; d++) begin
            n_cmp++; if (ready_w[d] !== m_run[d] || pvld_w[d] !== m_vld[d]) begin
               n_bad++; $display("FAIL rand_ctl[%0d] c%0d: ready %b vld %b want %b %b", d, c, ready_w[d], pvld_w[d], m_run[d], m_vld[d]); end
            n_cmp++; if (pctr_w[d] !== 2'(m_ctr[d]) || ptkn_w[d] !== (m_ctr[d] >= 2)) begin
               n_bad++; $display("FAIL rand_ctr[%0d] c%0d: got %0d tk %b want %0d", d, c, pctr_w[d], ptkn_w[d], m_ctr[d]); end
            n_cmp++; if (pidx_w[d] !== 8'(m_idx[d])) begin
               n_bad++; $display("FAIL rand_idx[%0d] c%0d: got %h want %h", d, c, pidx_w[d], m_idx[d]); end
         end
         n_cmp++; if (ghr_a !== 8'(m_ghr[0]) || ghr_b !== 1'b0) begin
            n_bad++; $display("FAIL rand_ghr c%0d: got %h/%b want %h/0", c, ghr_a, ghr_b, m_ghr[0]); end
      end
      clear = 1'b0; pred_req = 1'b0; upd_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_collision();
      test_clear();
      test_gshare();
      test_bimodal();
      test_midsweep_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
